serial_rx: RTL and testbench
============================

# serial_rx

Framed serial receiver that sits directly downstream of the parallel-to-serial shift register in the serial path. It synchronizes the incoming serial line, detects a start bit, samples N data bits LSB-first at mid-bit, checks the stop bit, and presents the assembled word on a valid/ready output port. It also flags framing errors and overruns.

## Interface
- N, default 8: data bits per frame; legal range ≥1.
- CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range ≥4.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- sin  in  1  serial line, idle high, asynchronous to clk.
- dout  out  N  received word, LSB = first data bit received.
- valid  out  1  dout holds an unconsumed word.
- ready  in  1  consumer accepts dout when valid && ready.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overrun  out  1  one-cycle pulse when a good frame is dropped because valid is still held.

## Operation
- Frame format: 1 start bit (0), N data bits LSB-first, 1 stop bit (1).
- Input conditioning: sin passes through a 2-flop synchronizer, which resets to 1. All decisions use the synchronized value (rxs).
- Internal state:
  - bit-timer counter, width clog2(CLKS_PER_BIT);
  - bit counter, width clog2(N+1);
  - N-bit shift register.
- States:
  - IDLE: on rxs==0, clear the timer and go to START.
  - START: when the timer reaches CLKS_PER_BIT/2−1 (floor), sample rxs.
    - rxs==1: false start (glitch). Return to IDLE.
    - rxs==0: clear the timer and bit counter, go to DATA.
  - DATA: when the timer reaches CLKS_PER_BIT−1:
    - shift in rxs: shreg <= {rxs, shreg[N-1:1]};
    - increment the bit counter and clear the timer;
    - after the Nth sample, go to STOP.
  - STOP: when the timer reaches CLKS_PER_BIT−1, sample rxs.
    - rxs==1: deliver the word and go to IDLE.
    - rxs==0: pulse frame_err, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a held-low line (break) from retriggering.
- Delivery rules, all in the cycle after the stop sample:
  - valid==0: load dout, set valid.
  - valid==1 and ready==1 in the same cycle: load the new word into dout; valid stays 1; no overrun.
  - valid==1 and ready==0: keep the old dout, pulse overrun, drop the new word.
- Consumption: valid && ready with no concurrent delivery clears valid on the next edge. dout retains its last value.
- dout changes only on a load. The shift register is never visible on dout mid-frame.

## Timing
- Reset values: dout=0, valid=0, frame_err=0, overrun=0, state IDLE, synchronizer flops=1.
- Reset asserted mid-frame: the frame is aborted immediately (asynchronous) and the state returns to IDLE.
- Let t0 be the first cycle with rxs==0 in IDLE. t0 is 2 cycles after the sin falling edge.
  - Start sample: t0 + CLKS_PER_BIT/2.
  - Data bit k (k = 0..N−1) sample: t0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop sample: t0 + CLKS_PER_BIT/2 + (N+1)·CLKS_PER_BIT.
  - valid, frame_err and overrun are visible 1 cycle after the stop sample.
- Back-to-back frames: a next start bit beginning right at the end of the stop bit is received. IDLE is re-entered roughly half a bit before the next falling edge.
- frame_err and overrun are each exactly 1 cycle wide and never both high together.

## Test plan
Bench parameters: CLKS_PER_BIT=16, N=8. Frames are driven on sin with ideal bit timing.

- Reset low for 2 cycles, then line high for 300 cycles: valid, frame_err and overrun stay 0, and dout=8'h00.
- Frame 8'h2A (data bits 0,1,0,1,0,1,0,0), ready=1: valid=1 for exactly 1 cycle at t0+8+9·16+1 with dout=8'h2A. No error pulses.
- sin low for 5 cycles, then high (glitch shorter than half a bit): no valid and no frame_err. A subsequent frame 8'h81 is received correctly.
- Frame 8'h55 with stop bit 0, line then held low for 40 cycles, then high: one frame_err pulse and valid stays 0. After the line returns high, the next frame 8'hA5 yields dout=8'hA5.
- ready=0; send 8'h11 then 8'h22 back-to-back:
  - after the first frame, dout=8'h11 and valid=1;
  - at the second frame, overrun pulses once and dout stays 8'h11;
  - raising ready clears valid on the next edge.
- Reset pulsed low during data bit 3 of frame 8'hFF: all outputs read 0 immediately and no valid follows. The next full frame 8'hC3 yields dout=8'hC3.

Source files
------------

// File: rtl/serial_rx.sv
// serial_rx: framed serial receiver (1 start, N data LSB-first, 1 stop).
// Two-flop input synchronizer, mid-bit sampling driven by a bit timer,
// valid/ready output port with framing-error and overrun pulses.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   S_IDLE      | line idle, waiting for rxs==0
//   S_START     | timing to mid start bit to confirm it is not a glitch
//   S_DATA      | sampling N data bits at mid-bit, LSB first
//   S_STOP      | sampling the stop bit; deliver word or flag framing error
//   S_WAIT_HIGH | after a bad stop bit, hold until the line returns high
module serial_rx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  output logic [N-1:0] dout,
  output logic         valid,
  input  logic         ready,
  output logic         frame_err,
  output logic         overrun
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = ($clog2(N + 1) > 0) ? $clog2(N + 1) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic          deliver;
  logic          bad_stop;

  assign rxs = sync_q[1];

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], sin};
  end

  // FSM state, bit timer, bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
    end
  end

  // Next-state logic: the timer free-runs and is cleared at each bit boundary.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (timer_q == T_HALF) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            timer_d  = '0;
            bitcnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (timer_q == T_FULL) begin
          // Shift right, new bit enters at the MSB so the first bit ends at LSB.
          shreg_d        = shreg_q >> 1;
          shreg_d[N-1]   = rxs;
          bitcnt_d       = bitcnt_q + 1'b1;
          timer_d        = '0;
          if (bitcnt_q == B_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == T_FULL) begin
          if (rxs) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        timer_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output port: load on delivery when the slot is free or being consumed,
  // otherwise drop the word and pulse overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= deliver && valid && !ready;
      if (deliver && (!valid || ready)) begin
        dout  <= shreg_q;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: directed frames plus randomized frames, checked
// against a word-level model of the output port (expected word, valid flag).
module tb_serial_rx;

  localparam int N   = 8;
  localparam int CPB = 16;
  localparam int FRM = (N + 2) * CPB;
  // Cycle offset (from the start-bit drive edge) at which the outcome is
  // visible: 2 sync cycles + half bit + (N+1) bits + 1 register stage.
  localparam int T_OUT = 2 + CPB / 2 + (N + 1) * CPB + 1;

  logic         clk;
  logic         rst;
  logic         sin;
  logic [N-1:0] dout;
  logic         valid;
  logic         ready;
  logic         frame_err;
  logic         overrun;

  int n_chk  = 0;
  int n_pass = 0;

  int val_cnt  = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int both_cnt = 0;

  logic [N-1:0] m_dout  = '0;
  logic         m_valid = 1'b0;

  serial_rx #(.N(N), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .dout      (dout),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/level counters sampled on the falling edge.
  always @(negedge clk) begin
    if (valid) val_cnt++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame with ideal timing starting just after a rising edge and
  // checks the port around the cycle where the frame's outcome must appear.
  task automatic send_frame(input logic [N-1:0] data, input logic stop, input logic rdy);
    logic [N+1:0] bits;
    logic         exp_ov;
    bits   = {stop, data, 1'b0};
    exp_ov = 1'b0;
    ready  = rdy;
    for (int i = 0; i < FRM; i++) begin
      sin = bits[i / CPB];
      if (i == 1 && rdy) m_valid = 1'b0;
      if (i == T_OUT - 1) begin
        chk("valid_pre", valid, m_valid);
        chk("dout_pre", dout, m_dout);
      end
      if (i == T_OUT) begin
        if (stop) begin
          if (!m_valid || rdy) begin
            m_dout  = data;
            m_valid = 1'b1;
          end else begin
            exp_ov = 1'b1;
          end
        end
        chk("frame_err", frame_err, !stop);
        chk("overrun", overrun, exp_ov);
        chk("valid", valid, m_valid);
        chk("dout", dout, m_dout);
      end
      if (i == T_OUT + 1) begin
        if (rdy) m_valid = 1'b0;
        chk("frame_err_w", frame_err, 0);
        chk("overrun_w", overrun, 0);
        chk("valid_post", valid, m_valid);
        chk("dout_post", dout, m_dout);
      end
      @(posedge clk);
      #1;
    end
  endtask

  int v0, f0, o0;

  initial begin
    rst   = 1'b0;
    sin   = 1'b1;
    ready = 1'b0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle line
    v0 = val_cnt; f0 = fe_cnt; o0 = ov_cnt;
    wait_cyc(300);
    chk("idle_valid", val_cnt - v0, 0);
    chk("idle_fe", fe_cnt - f0, 0);
    chk("idle_ov", ov_cnt - o0, 0);
    chk("idle_dout", dout, 0);

    // Basic frame, one-cycle valid with ready high
    v0 = val_cnt;
    send_frame(8'h2A, 1'b1, 1'b1);
    chk("2a_valid_cycles", val_cnt - v0, 1);
    wait_cyc(10);

    // Glitch shorter than half a bit
    v0 = val_cnt; f0 = fe_cnt;
    sin = 1'b0;
    wait_cyc(5);
    sin = 1'b1;
    wait_cyc(30);
    chk("glitch_valid", val_cnt - v0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_cyc(10);

    // Bad stop bit followed by a held-low line
    f0 = fe_cnt; v0 = val_cnt;
    send_frame(8'h55, 1'b0, 1'b1);
    sin = 1'b0;
    wait_cyc(40);
    sin = 1'b1;
    wait_cyc(20);
    chk("break_fe_pulses", fe_cnt - f0, 1);
    chk("break_valid", val_cnt - v0, 0);
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_cyc(10);

    // Overrun: ready low, two back-to-back frames
    o0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ovr_pulses", ov_cnt - o0, 1);
    ready = 1'b1;
    wait_cyc(1);
    m_valid = 1'b0;
    chk("ovr_consume_valid", valid, 0);
    chk("ovr_consume_dout", dout, 8'h11);
    wait_cyc(10);

    // Reset during data bit 3 of 8'hFF
    sin = 1'b0;
    wait_cyc(CPB);
    sin = 1'b1;
    wait_cyc(3 * CPB + CPB / 2);
    rst = 1'b0;
    #1;
    m_dout = '0; m_valid = 1'b0;
    chk("amid_dout", dout, 0);
    chk("amid_valid", valid, 0);
    chk("amid_fe", frame_err, 0);
    chk("amid_ov", overrun, 0);
    wait_cyc(2);
    rst = 1'b1;
    v0 = val_cnt;
    wait_cyc(150);
    chk("amid_no_valid", val_cnt - v0, 0);
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_cyc(5);

    // Randomized frames: random data, stop bit, ready and inter-frame gap
    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] d;
      logic         st;
      logic         rd;
      int           gap;
      d   = N'($urandom_range(0, (1 << N) - 1));
      st  = ($urandom_range(0, 3) != 0);
      rd  = 1'($urandom_range(0, 1));
      gap = st ? int'($urandom_range(0, 12)) : 20 + int'($urandom_range(0, 10));
      send_frame(d, st, rd);
      sin = 1'b1;
      wait_cyc(gap);
    end

    chk("excl_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
